// File: rtl/seq_mult32_cla_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : seq_mult32_cla_pkg
//  Description : Shared constants and FSM state encoding for the sequential
//                32x32 shift-add multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_mult32_cla_pkg;

    // Operand width; fixed by the 32-bit CLA used as the iteration adder.
    localparam int MULT_WIDTH = 32;
    // Iteration counter width; must be able to hold the value MULT_WIDTH.
    localparam int MULT_CNT_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_mult32_cla_adder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : CLA32bit
//  Description : 32-bit carry-look-ahead adder. Eight 4-bit lookahead groups;
//                each group produces its carry-out from group generate and
//                propagate terms, so the carry crosses one group per level.
//  Ports       : a, b   - 32-bit addends
//                cin    - carry in
//                sum    - 32-bit sum
//                cout   - carry out
//  Revision    : 1.0 - initial release
// ============================================================================
module CLA32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [31:0] w_g;
    logic [31:0] w_p;
    logic [32:0] w_c;

    assign w_g    = a & b;
    assign w_p    = a ^ b;
    assign w_c[0] = cin;

    for (genvar gi = 0; gi < 8; gi++) begin : g_grp
        localparam int B = 4 * gi;
        logic w_gg;
        logic w_pg;

        assign w_c[B+1] = w_g[B]   | (w_p[B]   & w_c[B]);
        assign w_c[B+2] = w_g[B+1] | (w_p[B+1] & w_g[B])
                        | (w_p[B+1] & w_p[B] & w_c[B]);
        assign w_c[B+3] = w_g[B+2] | (w_p[B+2] & w_g[B+1])
                        | (w_p[B+2] & w_p[B+1] & w_g[B])
                        | (w_p[B+2] & w_p[B+1] & w_p[B] & w_c[B]);

        // Group generate/propagate give the carry into the next group.
        assign w_gg = w_g[B+3] | (w_p[B+3] & w_g[B+2])
                    | (w_p[B+3] & w_p[B+2] & w_g[B+1])
                    | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_g[B]);
        assign w_pg = &w_p[B+3:B];

        assign w_c[B+4] = w_gg | (w_pg & w_c[B]);
    end

    assign sum  = w_p ^ w_c[31:0];
    assign cout = w_c[32];

endmodule
`default_nettype wire

// File: rtl/seq_mult32_cla.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : seq_mult32_cla
//  Description : Unsigned 32x32 -> 64-bit shift-add multiplier. One partial
//                product is added per cycle through a single CLA32bit. One
//                multiply in flight; valid/ready on both sides.
//  Ports       : clk, rst_n                  - clock, async active-low reset
//                in_valid/in_ready           - operand handshake
//                multiplicand, multiplier    - operands, sampled on accept
//                out_valid/out_ready         - result handshake
//                product                     - 64-bit result, stable while valid
//                busy                        - high while BUSY or DONE
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_mult32_cla
    import seq_mult32_cla_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,   // only 32 is supported (CLA32bit width)
    parameter int CNT_W = MULT_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH);

    state_t             r_state;
    logic [WIDTH-1:0]   r_m;
    logic [WIDTH-1:0]   r_p_hi;
    logic [WIDTH-1:0]   r_p_lo;
    logic [CNT_W-1:0]   r_cnt;

    logic [WIDTH-1:0]   w_b;
    logic [WIDTH-1:0]   w_sum;
    logic               w_cout;

    // Partial product for this iteration: multiplicand or zero by the
    // current low multiplier bit.
    assign w_b = r_p_lo[0] ? r_m : '0;

    CLA32bit u_cla (
        .a    (r_p_hi),
        .b    (w_b),
        .cin  (1'b0),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // The 65-bit {carry, P_hi, P_lo} shift always brings a zero into the
    // carry position, so the adder carry-out lands directly in P_hi[MSB]
    // and no separate carry flop is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_m       <= '0;
            r_p_hi    <= '0;
            r_p_lo    <= '0;
            r_cnt     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            product   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        r_m      <= multiplicand;
                        r_p_lo   <= multiplier;
                        r_p_hi   <= '0;
                        r_cnt    <= '0;
                        r_state  <= ST_BUSY;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == C_LAST) begin
                        product   <= {r_p_hi, r_p_lo};
                        out_valid <= 1'b1;
                        r_state   <= ST_DONE;
                    end else begin
                        r_p_hi <= {w_cout, w_sum[WIDTH-1:1]};
                        r_p_lo <= {w_sum[0], r_p_lo[WIDTH-1:1]};
                        r_cnt  <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    // Illegal encoding: fall back to a clean idle.
                    r_state   <= ST_IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
